// File: rtl/uart_tx_frame.sv
// UART transmit framer: valid/ready word input, programmable baud divider,
// runtime data length (5..DATA_W), optional even/odd parity and 1 or 2 stop bits.
module uart_tx_frame #(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 13
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DIV_W-1:0]  baud_div,
  input  logic [3:0]        data_len,
  input  logic [1:0]        parity_mode,
  input  logic              stop2,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              tx_out,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  state_t              state_r, state_s;
  logic [DIV_W-1:0]    cnt_r, cnt_s;
  logic [DIV_W-1:0]    div_r, div_s;
  logic [3:0]          len_r, len_s;
  logic [3:0]          idx_r, idx_s;
  logic [DATA_W-1:0]   shift_r, shift_s;
  logic                par_en_r, par_en_s;
  logic                par_r, par_s;
  logic                stop2_r, stop2_s;
  logic                stop_idx_r, stop_idx_s;
  logic                tx_r, tx_s;

  logic [3:0]          len_cl_s;
  logic [DATA_W-1:0]   masked_s;
  logic                bit_end_s;
  logic                last_stop_s;
  logic                accept_s;

  // Zero every data bit at or above the frame length.
  function automatic logic [DATA_W-1:0] mask_data(input logic [DATA_W-1:0] d,
                                                  input logic [3:0] len);
    logic [DATA_W-1:0] m;
    m = '0;
    for (int i = 0; i < DATA_W; i++) begin
      if (4'(i) < len) m[i] = d[i];
      else             m[i] = 1'b0;
    end
    return m;
  endfunction

  // Even parity over a word; odd parity is its inverse.
  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

  assign len_cl_s    = ((data_len < 4'd5) || (data_len > 4'(DATA_W))) ? 4'(DATA_W) : data_len;
  assign masked_s    = mask_data(in_data, len_cl_s);
  assign bit_end_s   = (cnt_r == '0);
  assign last_stop_s = (state_r == ST_STOP) && bit_end_s && (stop_idx_r == stop2_r);
  assign in_ready    = (state_r == ST_IDLE) || last_stop_s;
  assign accept_s    = in_valid && in_ready;
  assign done        = last_stop_s;
  assign busy        = (state_r != ST_IDLE);
  assign tx_out      = tx_r;

  // Next-state, bit timing and next serial level.
  always_comb begin
    state_s    = state_r;
    cnt_s      = bit_end_s ? div_r : (cnt_r - DIV_W'(1));
    div_s      = div_r;
    len_s      = len_r;
    idx_s      = idx_r;
    shift_s    = shift_r;
    par_en_s   = par_en_r;
    par_s      = par_r;
    stop2_s    = stop2_r;
    stop_idx_s = stop_idx_r;

    if (accept_s) begin
      state_s    = ST_START;
      cnt_s      = baud_div;
      div_s      = baud_div;
      len_s      = len_cl_s;
      idx_s      = 4'd0;
      shift_s    = masked_s;
      par_en_s   = (parity_mode == 2'b01) || (parity_mode == 2'b10);
      par_s      = even_parity(masked_s) ^ (parity_mode == 2'b10);
      stop2_s    = stop2;
      stop_idx_s = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          cnt_s = cnt_r;
        end
        ST_START: begin
          if (bit_end_s) begin
            state_s = ST_DATA;
            idx_s   = 4'd0;
          end else begin
            state_s = ST_START;
          end
        end
        ST_DATA: begin
          if (bit_end_s) begin
            shift_s = shift_r >> 1;
            idx_s   = idx_r + 4'd1;
            if (idx_r == (len_r - 4'd1)) begin
              state_s    = par_en_r ? ST_PARITY : ST_STOP;
              stop_idx_s = 1'b0;
            end else begin
              state_s = ST_DATA;
            end
          end else begin
            state_s = ST_DATA;
          end
        end
        ST_PARITY: begin
          if (bit_end_s) begin
            state_s    = ST_STOP;
            stop_idx_s = 1'b0;
          end else begin
            state_s = ST_PARITY;
          end
        end
        ST_STOP: begin
          if (last_stop_s) begin
            state_s = ST_IDLE;
            cnt_s   = '0;
          end else if (bit_end_s) begin
            stop_idx_s = 1'b1;
          end else begin
            state_s = ST_STOP;
          end
        end
        default: begin
          state_s = ST_IDLE;
          cnt_s   = '0;
        end
      endcase
    end

    case (state_s)
      ST_IDLE:   tx_s = 1'b1;
      ST_START:  tx_s = 1'b0;
      ST_DATA:   tx_s = shift_s[0];
      ST_PARITY: tx_s = par_s;
      ST_STOP:   tx_s = 1'b1;
      default:   tx_s = 1'b1;
    endcase
  end

  // State and datapath registers; reset abandons any frame and drives the line high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      cnt_r      <= '0;
      div_r      <= '0;
      len_r      <= 4'd0;
      idx_r      <= 4'd0;
      shift_r    <= '0;
      par_en_r   <= 1'b0;
      par_r      <= 1'b0;
      stop2_r    <= 1'b0;
      stop_idx_r <= 1'b0;
      tx_r       <= 1'b1;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      div_r      <= div_s;
      len_r      <= len_s;
      idx_r      <= idx_s;
      shift_r    <= shift_s;
      par_en_r   <= par_en_s;
      par_r      <= par_s;
      stop2_r    <= stop2_s;
      stop_idx_r <= stop_idx_s;
      tx_r       <= tx_s;
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame: expected line levels come from a
// bit-list model of the frame format, replayed clock by clock.
module tb_uart_tx_frame;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [12:0] baud_div;
  logic [3:0]  data_len;
  logic [1:0]  parity_mode;
  logic        stop2;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        tx_out;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;
  bit exp_q[$];

  uart_tx_frame #(.DATA_W(8), .DIV_W(13)) dut (
    .clk(clk), .rst_n(rst_n), .baud_div(baud_div), .data_len(data_len),
    .parity_mode(parity_mode), .stop2(stop2), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .tx_out(tx_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Append one frame's line levels (one entry per bit period) to exp_q.
  task automatic build_frame(input logic [7:0] d, input int len, input int pm, input bit s2);
    int eff;
    int ones;
    eff  = (len < 5 || len > 8) ? 8 : len;
    ones = 0;
    exp_q.push_back(1'b0);
    for (int i = 0; i < eff; i++) begin
      exp_q.push_back(d[i]);
      ones += d[i];
    end
    if (pm == 1) exp_q.push_back((ones % 2) == 1);
    if (pm == 2) exp_q.push_back((ones % 2) == 0);
    exp_q.push_back(1'b1);
    if (s2) exp_q.push_back(1'b1);
  endtask

  // Present a word and wait (bounded) until it is taken; returns at frame clock 0.
  task automatic start_word(input logic [7:0] d, input logic [3:0] len, input logic [1:0] pm,
                            input bit s2, input logic [12:0] div);
    int t;
    in_data = d; data_len = len; parity_mode = pm; stop2 = s2; baud_div = div;
    in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 1000) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL accept_timeout: in_ready=%0b required 1", in_ready);
    end
    @(negedge clk);
  endtask

  // Compare every clock of exp_q against the line, plus busy/done/in_ready.
  task automatic check_stream(input int bit_clks, input int frame_bits,
                              input int drop_at, input bit scramble);
    int total;
    int flen;
    int dones;
    bit last;
    total = exp_q.size() * bit_clks;
    flen  = frame_bits * bit_clks;
    dones = 0;
    for (int k = 0; k < total; k++) begin
      if (k == drop_at) in_valid = 1'b0;
      if (k == 0 && scramble) begin
        in_data = 8'($urandom); data_len = 4'($urandom);
        parity_mode = 2'($urandom); stop2 = 1'($urandom); baud_div = 13'($urandom);
      end
      last = ((k + 1) % flen) == 0;
      checks += 4;
      if (tx_out !== exp_q[k / bit_clks]) begin
        errors++;
        $display("FAIL tx_out clk %0d: got %0b required %0b", k, tx_out, exp_q[k / bit_clks]);
      end
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL busy clk %0d: got %0b required 1", k, busy);
      end
      if (done !== last) begin
        errors++;
        $display("FAIL done clk %0d: got %0b required %0b", k, done, last);
      end
      if (in_ready !== last) begin
        errors++;
        $display("FAIL in_ready clk %0d: got %0b required %0b", k, in_ready, last);
      end
      if (done === 1'b1) dones++;
      @(negedge clk);
    end
    checks += 3;
    if (dones != total / flen) begin
      errors++;
      $display("FAIL done_count: got %0d required %0d", dones, total / flen);
    end
    if (tx_out !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL post_idle: tx_out=%0b busy=%0b required 1/0", tx_out, busy);
    end
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL post_done: got %0b required 0", done);
    end
  endtask

  task automatic run_frame(input logic [7:0] d, input logic [3:0] len, input logic [1:0] pm,
                           input bit s2, input logic [12:0] div, input bit scramble);
    exp_q.delete();
    build_frame(d, int'(len), int'(pm), s2);
    start_word(d, len, pm, s2, div);
    check_stream(int'(div) + 1, exp_q.size(), 0, scramble);
  endtask

  task automatic test_reset();
    checks += 4;
    if (tx_out !== 1'b1) begin errors++; $display("FAIL reset_tx: got %0b required 1", tx_out); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b required 0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b required 0", done); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b required 1", in_ready); end
  endtask

  task automatic test_8n1();
    run_frame(8'hA5, 4'd8, 2'b00, 1'b0, 13'd3, 1'b0);
  endtask

  task automatic test_7e2();
    run_frame(8'h41, 4'd7, 2'b01, 1'b1, 13'd1, 1'b0);
  endtask

  task automatic test_8o1();
    run_frame(8'h07, 4'd8, 2'b10, 1'b0, 13'd0, 1'b0);
  endtask

  task automatic test_len_clamp();
    run_frame(8'($urandom), 4'd12, 2'b01, 1'b0, 13'd2, 1'b1);
    run_frame(8'hFF, 4'd6, 2'b10, 1'b1, 13'd1, 1'b1);
  endtask

  task automatic test_back_to_back();
    exp_q.delete();
    build_frame(8'h55, 8, 0, 1'b0);
    build_frame(8'hAA, 8, 0, 1'b0);
    start_word(8'h55, 4'd8, 2'b00, 1'b0, 13'd1);
    in_data = 8'hAA;
    check_stream(2, 10, 20, 1'b0);
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    d = 8'($urandom);
    exp_q.delete();
    build_frame(d, 8, 0, 1'b0);
    start_word(d, 4'd8, 2'b00, 1'b0, 13'd3);
    in_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (tx_out !== exp_q[k / 4]) begin
        errors++;
        $display("FAIL pre_reset_tx clk %0d: got %0b required %0b", k, tx_out, exp_q[k / 4]);
      end
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_frame(8'h3C, 4'd8, 2'b01, 1'b1, 13'd2, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 25; n++) begin
      run_frame(8'($urandom), 4'($urandom), 2'($urandom), 1'($urandom),
                13'($urandom_range(0, 3)), 1'b1);
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; data_len = 4'd8;
    parity_mode = 2'b00; stop2 = 1'b0; baud_div = 13'd0;
    @(negedge clk);
    @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_8n1();
    test_7e2();
    test_8o1();
    test_len_clamp();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
